// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Provides access-size and FSM state enums, plus size/byte-mask helpers.
// Imported by data_mem_responder and load_aligner.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Access width in bytes: 1, 2, 4 or 8.
    function automatic logic [3:0] size_bytes(input size_t size);
        return 4'd1 << size;
    endfunction

    // Byte lanes touched by an access of the given size at the given lane offset.
    // Bits shifted past lane 7 are dropped; such accesses are misaligned anyway.
    function automatic logic [7:0] byte_mask(input size_t size, input logic [2:0] offset);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << offset;
    endfunction

endpackage

// File: rtl/data_mem_responder_load_aligner.sv
// Load aligner: extracts a byte/half/word/double field from a 64-bit word.
// Ports: word (storage word), offset (byte lane), size, is_unsigned -> result.
// Purely combinational; the field is shifted to bit 0 and sign/zero extended.
module load_aligner (
    input  logic [63:0] word,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] result
);
    import mem_resp_pkg::*;

    logic [63:0] shifted;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        case (size_t'(size))
            SZ_B:    result = is_unsigned ? {56'd0, shifted[7:0]}
                                          : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H:    result = is_unsigned ? {48'd0, shifted[15:0]}
                                          : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W:    result = is_unsigned ? {32'd0, shifted[31:0]}
                                          : {{32{shifted[31]}}, shifted[31:0]};
            default: result = shifted;  // double: extension is meaningless
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port memory responder: one outstanding sized load/store, 64-bit word storage.
// Ports: req_* valid/ready request in; resp_* valid/ready response out (rdata, err).
// Response appears LATENCY cycles after accept and is held until resp_ready.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);
    import mem_resp_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    size_t       size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic        resp_valid_q, resp_valid_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    // Storage is deliberately not reset.
    logic [63:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic [63:0]   word_rd;
    logic          misaligned;
    logic          out_of_range;
    logic          access_err;
    logic [7:0]    wmask;
    logic [63:0]   wshift;
    logic [63:0]   merged;
    logic [63:0]   load_data;
    logic          mem_we;

    assign idx          = addr_q[3 +: AW];
    assign word_rd      = mem[idx];
    assign out_of_range = addr_q[63:3] >= 61'(DEPTH);
    assign misaligned   = ({1'b0, addr_q[2:0]} & (size_bytes(size_q) - 4'd1)) != 4'd0;
    assign access_err   = out_of_range | misaligned;

    // Store merge: place wdata at the lane offset and replace only masked lanes.
    always_comb begin
        wmask  = byte_mask(size_q, addr_q[2:0]);
        wshift = wdata_q << {addr_q[2:0], 3'b000};
        merged = word_rd;
        for (int i = 0; i < 8; i++) begin
            if (wmask[i]) begin
                merged[i*8 +: 8] = wshift[i*8 +: 8];
            end
        end
    end

    load_aligner u_load_aligner (
        .word        (word_rd),
        .offset      (addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .result      (load_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    size_d     = size_t'(req_size);
                    unsigned_d = req_unsigned;
                    cnt_d      = 4'(LATENCY - 1);
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    // Access executes on this edge; mem_we is low whenever
                    // reset has forced the FSM back to IDLE.
                    mem_we       = write_q & ~access_err;
                    resp_valid_d = 1'b1;
                    resp_err_d   = access_err;
                    resp_rdata_d = (!write_q && !access_err) ? load_data : 64'd0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 64'd0;
                    resp_err_d   = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            size_q       <= SZ_B;
            unsigned_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[idx] <= merged;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
